serial_in_parallel_out_shift_reg: RTL
=====================================

// Module: serial_in_parallel_out_shift_reg
//
// PURPOSE
// Receive-side partner of the parallel-in/serial-out shifter: collects an LSB-first
// serial bit stream, qualified per bit by din_en, into DATA_WIDTH-bit words.
// Each completed word is presented on a registered parallel output with a valid/ready
// handshake. A one-word holding register lets the next word be shifted in while the
// current one waits for the consumer. Sits between a serial link and word-wide logic.
//
// PARAMETERS
// DATA_WIDTH  16  bits per word; legal range >= 2; bit counter width = $clog2(DATA_WIDTH)
//
// PORTS
// clk         in   1           single clock, all state updates on posedge
// resetn      in   1           asynchronous, active-low reset
// din         in   1           serial data bit; sampled only when din_en=1
// din_en      in   1           bit-valid qualifier; one bit accepted per cycle with din_en=1
// clr         in   1           sync clear of the partial word (counter + shift reg); holding reg untouched
// dout        out  DATA_WIDTH  completed word; first received bit in dout[0]
// dout_valid  out  1           dout holds an unconsumed word
// dout_ready  in   1           consumer accepts dout when dout_valid & dout_ready at posedge
// overrun     out  1           one-cycle pulse: a word completed while the holding reg was full and not draining
// bit_cnt     out  $clog2(W)   number of bits of the partial word received so far (debug/status)
//
// BEHAVIOUR
// - Reset (resetn=0, async): shift reg=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0.
//   Reset mid-word discards the partial word and any held word; no output is produced for it.
// - Shift: on din_en=1, shreg <= {din, shreg[W-1:1]}, bit_cnt++. With din_en=0, nothing changes.
// - Completion: din_en=1 with bit_cnt==W-1 completes the word, i.e. {din, shreg[W-1:1]}.
//   bit_cnt wraps to 0 in the same edge. Back-to-back words need no idle cycle.
// - Holding register: two states, EMPTY (dout_valid=0) and FULL (dout_valid=1).
//   EMPTY + completion -> FULL; dout <= completed word. Valid from the next edge (latency 1 after last bit).
//   FULL + dout_ready (consumed), no completion -> EMPTY; dout keeps its last value.
//   FULL + dout_ready + completion (same cycle) -> stay FULL; dout <= new word, no overrun.
//   FULL + !dout_ready + completion -> stay FULL; the held word is kept and the new word is dropped.
//   overrun=1 for exactly the following cycle. Shifting continues (bit_cnt already wrapped to 0).
// - dout/dout_valid are stable while dout_valid=1 and dout_ready=0.
// - clr=1: bit_cnt<=0, shreg<=0 and any completion in that cycle is suppressed (clr wins over din_en).
//   The holding reg and dout_ready handling proceed normally.
// - overrun is 0 in every cycle not described above. All outputs are registered.
//
// TESTING
// 1 W=16, feed 16'hA5C3 LSB-first, din_en=1 for 16 cycles, dout_ready=1 -> dout_valid=1 the cycle
//   after bit 15, dout=16'hA5C3, then dout_valid=0.
// 2 Same word with din_en toggling 1/0 every cycle (32 cycles) -> dout=16'hA5C3.
//   bit_cnt only advances on din_en=1.
// 3 Back-to-back 16'h1234 then 16'hFFFF, dout_ready=0 until both are sent -> dout=16'h1234 held,
//   overrun pulses once after bit 31, then dout_ready=1 -> dout_valid drops, no second word.
// 4 dout_ready=1 in the exact cycle the second word's last bit arrives -> dout switches 16'h1234->16'h5678,
//   dout_valid stays 1, overrun=0.
// 5 Async reset after 7 bits, then a full 16'h00FF -> no output for the partial word, dout=16'h00FF, bit_cnt=0 at reset.
// 6 clr=1 after 9 bits, then 16 bits of 16'hBEEF -> dout=16'hBEEF. clr coincident with the 16th bit -> no dout_valid.

Source files
------------

// File: rtl/serial_in_parallel_out_shift_reg.sv
// serial_in_parallel_out_shift_reg: LSB-first serial-to-parallel converter with one-word holding register and valid/ready output
module serial_in_parallel_out_shift_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          din,
  input  logic                          din_en,
  input  logic                          clr,
  input  logic                          dout_ready,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          dout_valid,
  output logic                          overrun,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, word;
  logic complete, load, overrun_nxt;
  assign word = {din, shreg[DATA_WIDTH-1:1]};
  assign complete = din_en && !clr && bit_cnt == LAST;
  assign dout_valid = state == FULL;
  // partial-word shifter; clr beats din_en so a clearing cycle never completes a word
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      shreg <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      shreg <= '0;
      bit_cnt <= '0;
    end else if (din_en) begin
      shreg <= word;
      bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
    end
  // holding register next state: a new word lands only if the slot is empty or draining this cycle
  always_comb begin
    load = complete && (state == EMPTY || dout_ready);
    overrun_nxt = complete && state == FULL && !dout_ready;
    state_nxt = (load || (state == FULL && !dout_ready)) ? FULL : EMPTY;
  end
  // holding register, parallel output and overrun pulse
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= EMPTY;
      dout <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      overrun <= overrun_nxt;
      if (load) dout <= word;
    end
endmodule
